multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state of REQ-030.
REQ-004 opcode  input  5  instruction opcode field; sampled only in DECODE.
REQ-005 imem_valid  input  1  instruction word available on the fetch bus.
REQ-006 dmem_ready  input  1  data memory has completed the current read or write.
REQ-007 pc_we  output  1  PC update strobe.
REQ-008 ir_we  output  1  instruction register load strobe.
REQ-009 alu_src_imm  output  1  ALU B operand select: 1 = sign-extended immediate, 0 = register.
REQ-010 dmem_re  output  1  data memory read request.
REQ-011 dmem_we  output  1  data memory write request.
REQ-012 rf_we  output  1  register file write enable.
REQ-013 mem_to_reg  output  1  writeback select: 1 = memory data, 0 = ALU result.
REQ-014 retire  output  1  one-cycle pulse per completed legal instruction.
REQ-015 retire_cnt  output  16  saturating count of retired instructions.
REQ-016 illegal  output  1  sticky flag; set by any unrecognised opcode.

Function
REQ-017 Opcode classes: ALU=5'b00000, ADDI=5'b00101, SW=5'b00111, LW=5'b01000; every other value is ILLEGAL.
REQ-018 FSM states: FETCH, DECODE, EXEC, MEM, WB.
REQ-019 FETCH: hold while imem_valid=0; when imem_valid=1, pc_we=1 and ir_we=1 for exactly that cycle, then go to DECODE.
REQ-020 DECODE: one cycle; latch the opcode class into an internal register; ILLEGAL sets illegal=1 and returns to FETCH without retiring; legal classes go to EXEC.
REQ-021 Opcode changes after the DECODE cycle have no effect on the current instruction.
REQ-022 EXEC: one cycle; alu_src_imm=1 for ADDI, LW and SW, 0 for ALU; ALU and ADDI go to WB, LW and SW go to MEM.
REQ-023 MEM: dmem_re=1 (LW) or dmem_we=1 (SW), held every cycle until dmem_ready=1. dmem_ready=1 in the first MEM cycle completes in that cycle. On completion, SW retires and goes to FETCH; LW goes to WB.
REQ-024 dmem_ready outside MEM is ignored.
REQ-025 WB: one cycle; rf_we=1; mem_to_reg=1 for LW, 0 otherwise; retire and go to FETCH.
REQ-026 All strobe outputs are Moore functions of state plus the latched class; each strobe is 0 in every state not listed for it; dmem_re and dmem_we are never both 1.
REQ-027 Minimum latency in cycles, FETCH accept to retire pulse inclusive: ALU/ADDI 4; SW 4 + N wait cycles; LW 5 + N wait cycles.
REQ-028 retire_cnt increments by 1 on each retire; it holds at 16'hFFFF and does not wrap.
REQ-029 illegal, once set, clears only on reset.

Reset
REQ-030 On reset assertion, immediately (asynchronously): state=FETCH; all strobes, retire, illegal and retire_cnt =0; latched class=ALU.
REQ-031 Reset mid-MEM drops dmem_re/dmem_we without waiting for dmem_ready; no retire is issued for the aborted instruction.
REQ-032 After reset deassertion, the first action is a FETCH accept on the next rising edge with imem_valid=1.

Structure
REQ-033 A shared package holds the opcode constants, the class enum {ALU, ADDI, SW, LW, ILLEGAL} and the state enum.
REQ-034 The opcode-to-class mapping is one combinational sub-module, op_class_decode, instantiated once in multicycle_ctrl.

Verification
REQ-035 Reset, then opcode=00000 with imem_valid=1 -> pc_we/ir_we in cycle 1, rf_we=1 with mem_to_reg=0 in cycle 4, retire pulse in cycle 4, retire_cnt=1.
REQ-036 opcode=01000, dmem_ready low for 3 MEM cycles -> dmem_re high for exactly 4 cycles, then WB with rf_we=1 and mem_to_reg=1, retire_cnt+1.
REQ-037 opcode=00111, dmem_ready=1 in the first MEM cycle -> dmem_we high for 1 cycle, alu_src_imm=1 in EXEC, rf_we never 1, retire in the MEM cycle.
REQ-038 opcode=11111 -> illegal=1 after DECODE, no retire, back in FETCH; illegal stays 1 through subsequent legal instructions.
REQ-039 Assert reset during LW MEM with dmem_ready=0 -> dmem_re falls before the next clock edge, retire_cnt=0, FSM restarts in FETCH.
REQ-040 Preload or run 65535 retires, then run one more ADDI -> retire pulses, retire_cnt remains 16'hFFFF.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle instruction sequencer: opcode values,
// instruction classes, FSM states and retire-counter sizing.
package multicycle_ctrl_pkg;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_ADDI,
        CLS_SW,
        CLS_LW,
        CLS_ILLEGAL
    } op_class_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_e;

endpackage

// File: rtl/multicycle_ctrl_op_class_decode.sv
// Combinational opcode-to-class mapping; anything not recognised is ILLEGAL.
module op_class_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [4:0] opcode_i,
    output op_class_e  op_class_o
);

    always_comb begin
        op_class_o = CLS_ILLEGAL;
        case (opcode_i)
            OP_ALU:  op_class_o = CLS_ALU;
            OP_ADDI: op_class_o = CLS_ADDI;
            OP_SW:   op_class_o = CLS_SW;
            OP_LW:   op_class_o = CLS_LW;
            default: op_class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer: fetch/decode/exec/mem/writeback control
// strobes, retire pulse with saturating count, and a sticky illegal flag.
//
// state  | meaning
// FETCH  | wait for imem_valid; accept pulses pc_we/ir_we
// DECODE | latch opcode class; illegal opcodes flag and return to FETCH
// EXEC   | ALU operand select; route to MEM (loads/stores) or WB
// MEM    | hold dmem_re/dmem_we until dmem_ready; SW retires here
// WB     | register file write; retire
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       opcode,
    input  logic             imem_valid,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             alu_src_imm,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             mem_to_reg,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             illegal
);

    state_e           state_q, state_d;
    op_class_e        class_q, class_d;
    op_class_e        dec_class;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    op_class_decode u_op_class_decode (
        .opcode_i   (opcode),
        .op_class_o (dec_class)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            class_q      <= CLS_ALU;
            illegal_q    <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            class_q      <= class_d;
            illegal_q    <= illegal_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        illegal_d   = illegal_q;
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        alu_src_imm = 1'b0;
        dmem_re     = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        mem_to_reg  = 1'b0;
        retire      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // The accept strobes follow imem_valid, so mask them while reset is held.
                if (imem_valid && !reset) begin
                    pc_we   = 1'b1;
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                class_d = dec_class;
                if (dec_class == CLS_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_src_imm = (class_q != CLS_ALU);
                if (class_q == CLS_SW || class_q == CLS_LW) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_re = (class_q == CLS_LW);
                dmem_we = (class_q == CLS_SW);
                if (dmem_ready) begin
                    if (class_q == CLS_SW) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we      = 1'b1;
                mem_to_reg = (class_q == CLS_LW);
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        retire_cnt_d = retire_cnt_q;
        if (retire && retire_cnt_q != CNT_MAX) begin
            retire_cnt_d = retire_cnt_q + 1'b1;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle strobe expectations are
// derived from each instruction's class and memory wait count.
module tb_multicycle_ctrl;

    localparam int C_ALU  = 0;
    localparam int C_ADDI = 1;
    localparam int C_SW   = 2;
    localparam int C_LW   = 3;
    localparam int C_ILL  = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  opcode;
    logic        imem_valid;
    logic        dmem_ready;
    logic        pc_we, ir_we, alu_src_imm, dmem_re, dmem_we, rf_we, mem_to_reg, retire;
    logic [15:0] retire_cnt;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;
    logic exp_illegal = 1'b0;

    wire [7:0] strobes = {pc_we, ir_we, alu_src_imm, dmem_re, dmem_we, rf_we, mem_to_reg, retire};

    multicycle_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .opcode      (opcode),
        .imem_valid  (imem_valid),
        .dmem_ready  (dmem_ready),
        .pc_we       (pc_we),
        .ir_we       (ir_we),
        .alu_src_imm (alu_src_imm),
        .dmem_re     (dmem_re),
        .dmem_we     (dmem_we),
        .rf_we       (rf_we),
        .mem_to_reg  (mem_to_reg),
        .retire      (retire),
        .retire_cnt  (retire_cnt),
        .illegal     (illegal)
    );

    always #5 clock = ~clock;

    function automatic int cls_of(input logic [4:0] op);
        case (op)
            5'b00000: return C_ALU;
            5'b00101: return C_ADDI;
            5'b00111: return C_SW;
            5'b01000: return C_LW;
            default:  return C_ILL;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One instruction from FETCH accept to return to FETCH, then one idle FETCH cycle.
    task automatic run_instr(input logic [4:0] op, input int n_wait);
        int         cls;
        int         len;
        logic       is_mem;
        logic       last_mem;
        logic [7:0] exp_v;
        cls = cls_of(op);
        case (cls)
            C_ILL:         len = 2;
            C_ALU, C_ADDI: len = 4;
            C_SW:          len = 4 + n_wait;
            default:       len = 5 + n_wait;
        endcase
        for (int k = 1; k <= len; k++) begin
            @(negedge clock);
            opcode     = (k <= 2) ? op : 5'($urandom);
            imem_valid = (k == 1) ? 1'b1 : 1'($urandom);
            is_mem     = (cls == C_SW || cls == C_LW) && k >= 4 && k <= 4 + n_wait;
            last_mem   = is_mem && (k == 4 + n_wait);
            dmem_ready = is_mem ? last_mem : 1'($urandom);
            exp_v = 8'h00;
            if (k == 1) begin
                exp_v[7] = 1'b1;
                exp_v[6] = 1'b1;
            end
            if (k == 3) exp_v[5] = (cls != C_ALU);
            if (is_mem) begin
                exp_v[4] = (cls == C_LW);
                exp_v[3] = (cls == C_SW);
                exp_v[0] = (cls == C_SW) && last_mem;
            end
            if (k == len && (cls == C_ALU || cls == C_ADDI || cls == C_LW)) begin
                exp_v[2] = 1'b1;
                exp_v[1] = (cls == C_LW);
                exp_v[0] = 1'b1;
            end
            #1 chk($sformatf("strobes op=%b k=%0d", op, k), 32'(strobes), 32'(exp_v));
        end
        if (cls == C_ILL) exp_illegal = 1'b1;
        else exp_cnt = (exp_cnt >= 65535) ? 65535 : exp_cnt + 1;
        @(negedge clock);
        imem_valid = 1'b0;
        opcode     = 5'($urandom);
        dmem_ready = 1'($urandom);
        #1;
        chk("retire_cnt", 32'(retire_cnt), 32'(exp_cnt));
        chk("illegal", 32'(illegal), 32'(exp_illegal));
        chk("idle_strobes", 32'(strobes), 32'h0);
    endtask

    initial begin
        logic [4:0] op;
        reset      = 1'b1;
        imem_valid = 1'b1;
        opcode     = 5'b00000;
        dmem_ready = 1'b1;
        #3;
        chk("reset_strobes", 32'(strobes), 32'h0);
        chk("reset_cnt", 32'(retire_cnt), 32'h0);
        chk("reset_illegal", 32'(illegal), 32'h0);
        @(negedge clock);
        reset      = 1'b0;
        imem_valid = 1'b0;

        run_instr(5'b00000, 0);
        run_instr(5'b01000, 3);
        run_instr(5'b00111, 0);
        run_instr(5'b11111, 0);
        run_instr(5'b00101, 0);
        run_instr(5'b00000, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       op = 5'b00000;
                1:       op = 5'b00101;
                2:       op = 5'b00111;
                3:       op = 5'b01000;
                default: op = 5'($urandom);
            endcase
            run_instr(op, int'($urandom_range(0, 4)));
        end

        // Abort a load while it is stalled in MEM.
        @(negedge clock);
        opcode = 5'b01000; imem_valid = 1'b1; dmem_ready = 1'b0;
        @(negedge clock);
        imem_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1 chk("lw_mem_re", 32'(strobes), 32'h10);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("abort_strobes", 32'(strobes), 32'h0);
        chk("abort_cnt", 32'(retire_cnt), 32'h0);
        chk("abort_illegal", 32'(illegal), 32'h0);
        @(negedge clock);
        reset       = 1'b0;
        exp_cnt     = 0;
        exp_illegal = 1'b0;
        run_instr(5'b00000, 0);

        // Jump the counter close to its ceiling instead of running 65k instructions.
        @(negedge clock);
        imem_valid = 1'b0;
        force dut.retire_cnt_q = 16'hFFFE;
        @(negedge clock);
        release dut.retire_cnt_q;
        exp_cnt = 65534;
        #1 chk("preload_cnt", 32'(retire_cnt), 32'(exp_cnt));
        run_instr(5'b00101, 0);
        run_instr(5'b00101, 0);
        run_instr(5'b00111, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
